axi_stream_rr_arbiter: RTL and testbench
========================================

# axi_stream_rr_arbiter

N:1 round-robin arbiter that shares one registered valid/ready output stage among `NUM_REQ` upstream stream sources. It sits in front of a shared downstream processing stage and serialises requesters onto it, tagging each output beat with its source index. Packets can be kept contiguous using `last`. The output register uses the team's standard stage-enable rule: the stage accepts a beat when it is empty or the downstream consumes in the same cycle.

## Interface
- `NUM_REQ`, default 4: number of requesters; range 2..16.
- `DWIDTH`, default 8: data width per requester.
- `IDW`, default `$clog2(NUM_REQ)`: width of the source index.

Ports:
- `aclk_i`  in  1  clock, rising edge.
- `aresetn_i`  in  1  asynchronous, active-low reset; deassertion is synchronous to `aclk_i` externally.
- `s_valid_i`  in  NUM_REQ  per-requester valid.
- `s_data_i`  in  NUM_REQ*DWIDTH  requester k occupies bits [k*DWIDTH +: DWIDTH].
- `s_last_i`  in  NUM_REQ  per-requester end-of-packet.
- `s_ready_o`  out  NUM_REQ  per-requester ready; one-hot or zero.
- `m_valid_o`  out  1  output valid, registered.
- `m_data_o`  out  DWIDTH  output data, registered.
- `m_last_o`  out  1  output last, registered.
- `m_src_o`  out  IDW  source index of the current output beat, registered.
- `m_ready_i`  in  1  downstream ready.

## Operation
- Stage enable: `load_en = ~m_valid_o | m_ready_i`.
- State machine with two states, IDLE and LOCKED. It also holds a round-robin pointer `rr_ptr` (IDW bits) and an owner register `owner` (IDW bits).
- IDLE:
  - The winner is the first index with `s_valid_i` set, searching from `rr_ptr` upward with wrap-around (modulo NUM_REQ).
  - `s_ready_o[winner] = load_en`. All other `s_ready_o` bits are 0.
  - No valid requests: `s_ready_o` is all zero.
- Transfer on requester k: `s_valid_i[k] & s_ready_o[k]`. On a transfer:
  - the output register loads data, last and src = k;
  - `m_valid_o` is set to 1.
- IDLE, transfer with `s_last_i[k]=1`: `rr_ptr` becomes (k+1) mod NUM_REQ; state stays IDLE.
- IDLE, transfer with `s_last_i[k]=0`: `owner` becomes k; state goes to LOCKED (macro enabled only).
- LOCKED:
  - Only `s_ready_o[owner] = load_en`; every other requester is blocked, even while the owner's valid is low.
  - Transfer with last=1: `rr_ptr` becomes (owner+1) mod NUM_REQ; state returns to IDLE.
- No transfer and `m_ready_i=1`: `m_valid_o` is cleared to 0.
- No transfer and `m_ready_i=0`: all output registers hold.
- While `m_valid_o=1` and `m_ready_i=0`, all `s_ready_o` bits are 0. `m_data_o`, `m_last_o` and `m_src_o` stay stable.
- Arbitration logic is combinational from `s_valid_i`. `s_ready_o` may depend on `s_valid_i`; no upstream source may make `s_valid_i` depend on `s_ready_o`.

## Timing
- Reset (`aresetn_i=0`) takes effect immediately, without a clock:
  - outputs: `m_valid_o=0`, `m_data_o=0`, `m_last_o=0`, `m_src_o=0`;
  - internal: `rr_ptr=0`, `owner=0`, state IDLE.
  - While reset is asserted, `s_ready_o` is all zero.
- Latency: a beat accepted at rising edge n appears on `m_*` after edge n, and is valid in cycle n+1.
- Throughput: one beat per cycle with `m_ready_i` held at 1, including back-to-back beats from different requesters.
- Reset asserted mid-packet: the LOCKED state is discarded. The partially forwarded packet is not completed; upstream sources restart it.
- Simultaneous load and consume (`m_valid_o=1`, `m_ready_i=1`, transfer): the new beat replaces the old beat with no bubble cycle.

## Configuration
- Macro `ARB_PKT_LOCK_EN`.
- Defined: LOCKED state present. Packets from one requester are output contiguously.
- Undefined:
  - LOCKED state and `owner` are removed;
  - every beat is arbitrated independently;
  - after every transfer, `rr_ptr` becomes (k+1) mod NUM_REQ, regardless of last;
  - `s_last_i` is only forwarded to `m_last_o`.

## Test plan
- Single beat:
  - stimulus: after reset, requester 0 drives data 0x11 with last=1; `m_ready_i=1`;
  - response: `s_ready_o=4'b0001` in the same cycle; next cycle `m_valid_o=1`, `m_data_o=0x11`, `m_src_o=0`; then `m_valid_o=0`.
- Fairness:
  - stimulus: all 4 requesters continuously valid with single-beat packets (last=1); `m_ready_i=1`;
  - response: `m_src_o` sequence is 0,1,2,3,0,1 with no idle cycles.
- Backpressure:
  - stimulus: `m_ready_i=0` for 5 cycles while `m_valid_o=1` and data=0x22;
  - response: `s_ready_o=0` throughout and `m_data_o` holds 0x22; with `m_ready_i=1`, the next beat follows the cycle after.
- Packet lock, with `ARB_PKT_LOCK_EN` defined:
  - stimulus: requester 1 sends a 3-beat packet 0xA1, 0xA2, 0xA3, last on the 3rd beat; requester 2 is valid with 0xB0 throughout;
  - response: output is 0xA1, 0xA2, 0xA3, 0xB0.
  - Same stimulus without the macro: output is 0xA1, 0xB0, 0xA2, 0xA3.
- Wrap search:
  - stimulus: `rr_ptr=1` (after one packet from requester 0); only requesters 0 and 3 valid;
  - response: requester 3 wins, then requester 0.
- Reset mid-packet:
  - stimulus: drive `aresetn_i` low while LOCKED on requester 2;
  - response: `m_valid_o` is 0 immediately, before the next edge. After release, with all requesters valid, requester 0 wins first.

Source files
------------

// File: rtl/axi_stream_rr_arbiter.sv
// ============================================================================
//  Module   : axi_stream_rr_arbiter
//  Purpose  : N:1 round-robin stream arbiter with one registered output stage
//             tagging each beat with its source index. Define ARB_PKT_LOCK_EN
//             to keep packets (terminated by last) contiguous on the output.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_stream_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                      aclk_i,
    input  logic                      aresetn_i,
    input  logic [NUM_REQ-1:0]        s_valid_i,
    input  logic [NUM_REQ*DWIDTH-1:0] s_data_i,
    input  logic [NUM_REQ-1:0]        s_last_i,
    output logic [NUM_REQ-1:0]        s_ready_o,
    output logic                      m_valid_o,
    output logic [DWIDTH-1:0]         m_data_o,
    output logic                      m_last_o,
    output logic [IDW-1:0]            m_src_o,
    input  logic                      m_ready_i
);

    localparam logic [IDW-1:0] c_last_idx = IDW'(NUM_REQ - 1);
    localparam logic [IDW:0]   c_num_req  = (IDW+1)'(NUM_REQ);

    logic                  r_m_valid;
    logic [DWIDTH-1:0]     r_m_data;
    logic                  r_m_last;
    logic [IDW-1:0]        r_m_src;
    logic [IDW-1:0]        r_rr_ptr;

    logic                  w_load_en;
    logic [2*NUM_REQ-1:0]  w_valid_dbl;
    logic [NUM_REQ-1:0]    w_valid_rot;
    logic                  w_any_valid;
    logic [IDW-1:0]        w_offset;
    logic [IDW:0]          w_sum;
    logic [IDW-1:0]        w_rr_winner;
    logic [IDW-1:0]        w_sel;
    logic [IDW-1:0]        w_sel_inc;
    logic                  w_sel_en;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_xfer;
    logic [DWIDTH-1:0]     w_data;
    logic                  w_last;

    assign w_load_en   = ~r_m_valid | m_ready_i;
    assign w_any_valid = |s_valid_i;

    // Rotate valids so that bit 0 corresponds to the pointer position; the
    // lowest set bit is then the offset of the winner from the pointer.
    assign w_valid_dbl = {s_valid_i, s_valid_i} >> r_rr_ptr;
    assign w_valid_rot = w_valid_dbl[NUM_REQ-1:0];

    always_comb begin
        w_offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_valid_rot[i]) begin
                w_offset = IDW'(i);
            end
        end
    end

    assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_rr_winner = (w_sum >= c_num_req) ? IDW'(w_sum - c_num_req) : w_sum[IDW-1:0];

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_owner;

    // A locked owner keeps the grant even while its valid is low.
    assign w_sel    = (r_state == ST_LOCKED) ? r_owner : w_rr_winner;
    assign w_sel_en = (r_state == ST_LOCKED) | w_any_valid;
`else
    assign w_sel    = w_rr_winner;
    assign w_sel_en = w_any_valid;
`endif

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == IDW'(i)) begin
                w_grant[i] = w_sel_en & w_load_en & aresetn_i;
            end
        end
    end

    always_comb begin
        w_data = '0;
        w_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_data = s_data_i[i*DWIDTH +: DWIDTH];
                w_last = s_last_i[i];
            end
        end
    end

    assign w_xfer    = |(w_grant & s_valid_i);
    assign w_sel_inc = (w_sel == c_last_idx) ? '0 : w_sel + 1'b1;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_src   <= '0;
            r_rr_ptr  <= '0;
`ifdef ARB_PKT_LOCK_EN
            r_state   <= ST_IDLE;
            r_owner   <= '0;
`endif
        end else if (w_xfer) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_data;
            r_m_last  <= w_last;
            r_m_src   <= w_sel;
`ifdef ARB_PKT_LOCK_EN
            if (r_state == ST_LOCKED) begin
                if (w_last) begin
                    r_rr_ptr <= w_sel_inc;
                    r_state  <= ST_IDLE;
                end
            end else if (w_last) begin
                r_rr_ptr <= w_sel_inc;
            end else begin
                r_owner <= w_sel;
                r_state <= ST_LOCKED;
            end
`else
            r_rr_ptr  <= w_sel_inc;
`endif
        end else if (m_ready_i) begin
            r_m_valid <= 1'b0;
        end
    end

    assign s_ready_o = w_grant;
    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_m_data;
    assign m_last_o  = r_m_last;
    assign m_src_o   = r_m_src;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_rr_arbiter.sv
// ============================================================================
//  Module   : tb_axi_stream_rr_arbiter
//  Purpose  : Self-checking bench for axi_stream_rr_arbiter with a
//             behavioural reference model; honours ARB_PKT_LOCK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic             aclk    = 1'b0;
    logic             aresetn = 1'b0;
    logic [N-1:0]     s_valid = '0;
    logic [N*W-1:0]   s_data  = '0;
    logic [N-1:0]     s_last  = '0;
    logic [N-1:0]     s_ready;
    logic             m_valid;
    logic [W-1:0]     m_data;
    logic             m_last;
    logic [IW-1:0]    m_src;
    logic             m_ready = 1'b0;

    always #5 aclk = ~aclk;

    axi_stream_rr_arbiter #(
        .NUM_REQ (N),
        .DWIDTH  (W),
        .IDW     (IW)
    ) u_dut (
        .aclk_i    (aclk),
        .aresetn_i (aresetn),
        .s_valid_i (s_valid),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .s_ready_o (s_ready),
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_src_o   (m_src),
        .m_ready_i (m_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: abstract arbitration state kept as plain integers.
    int           mdl_ptr;
    int           mdl_owner;
    bit           mdl_locked;
    bit           mdl_valid;
    logic [W-1:0] mdl_data;
    bit           mdl_last;
    int           mdl_src;
    logic [N-1:0] mdl_rdy;

    task automatic mdl_reset();
        mdl_ptr    = 0;
        mdl_owner  = 0;
        mdl_locked = 1'b0;
        mdl_valid  = 1'b0;
        mdl_data   = '0;
        mdl_last   = 1'b0;
        mdl_src    = 0;
    endtask

    task automatic mdl_calc_ready();
        bit           load;
        int           idx;
        logic [N-1:0] vsh;
        load    = !mdl_valid || m_ready;
        mdl_rdy = '0;
        if (aresetn) begin
            if (mdl_locked) begin
                if (load) mdl_rdy = N'(1) << mdl_owner;
            end else begin
                for (int j = 0; j < N; j++) begin
                    idx = (mdl_ptr + j) % N;
                    vsh = s_valid >> idx;
                    if (vsh[0]) begin
                        if (load) mdl_rdy = N'(1) << idx;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic mdl_update();
        int           k;
        logic [N-1:0] hit;
        logic [N-1:0] lsh;
        logic [N*W-1:0] dsh;
        k   = -1;
        hit = s_valid & mdl_rdy;
        for (int j = 0; j < N; j++) begin
            lsh = hit >> j;
            if (lsh[0]) k = j;
        end
        if (k >= 0) begin
            dsh       = s_data >> (k * W);
            lsh       = s_last >> k;
            mdl_valid = 1'b1;
            mdl_data  = dsh[W-1:0];
            mdl_last  = lsh[0];
            mdl_src   = k;
`ifdef ARB_PKT_LOCK_EN
            if (mdl_locked) begin
                if (mdl_last) begin
                    mdl_ptr    = (mdl_owner + 1) % N;
                    mdl_locked = 1'b0;
                end
            end else if (mdl_last) begin
                mdl_ptr = (k + 1) % N;
            end else begin
                mdl_owner  = k;
                mdl_locked = 1'b1;
            end
`else
            mdl_ptr = (k + 1) % N;
`endif
        end else if (m_ready) begin
            mdl_valid = 1'b0;
        end
    endtask

    logic [N-1:0]  obs_rdy;
    logic          obs_valid;
    logic [W-1:0]  obs_data;
    logic [IW-1:0] obs_src;

    // One clock cycle: drive at the falling edge, sample and check, then
    // advance the model across the rising edge.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic [N-1:0] l, input logic r);
        @(negedge aclk);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = r;
        #1;
        obs_rdy   = s_ready;
        obs_valid = m_valid;
        obs_data  = m_data;
        obs_src   = m_src;
        mdl_calc_ready();
        chk("s_ready", 32'(s_ready), 32'(mdl_rdy));
        chk("m_valid", 32'(m_valid), 32'(mdl_valid));
        if (mdl_valid) begin
            chk("m_data", 32'(m_data), 32'(mdl_data));
            chk("m_last", 32'(m_last), 32'(mdl_last));
            chk("m_src",  32'(m_src),  mdl_src);
        end
        @(posedge aclk);
        mdl_update();
    endtask

    task automatic do_reset();
        @(negedge aclk);
        s_valid = '1;
        s_data  = '1;
        s_last  = '0;
        m_ready = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_data",  32'(m_data),  32'h0);
        chk("rst_m_last",  32'(m_last),  32'h0);
        chk("rst_m_src",   32'(m_src),   32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h0);
        mdl_reset();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
    endtask

    logic [N-1:0]   tv;
    logic [N*W-1:0] td;
    logic [N-1:0]   tl;
    logic [W-1:0]   got_q[$];
    logic [W-1:0]   exp_lock[4];
    int             fair_src[6] = '{0, 1, 2, 3, 0, 1};
    int             a_idx;
    bit             b_done;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef ARB_PKT_LOCK_EN
        exp_lock = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
`else
        exp_lock = '{8'hA1, 8'hB0, 8'hA2, 8'hA3};
`endif
        mdl_reset();
        do_reset();

        // Single beat from requester 0.
        step(4'b0001, 32'h0000_0011, 4'b0001, 1'b1);
        chk("single_rdy", 32'(obs_rdy), 32'h1);
        step('0, '0, '0, 1'b1);
        chk("single_valid", 32'(obs_valid), 32'h1);
        chk("single_data",  32'(obs_data),  32'h11);
        chk("single_src",   32'(obs_src),   32'h0);
        step('0, '0, '0, 1'b1);
        chk("single_empty", 32'(obs_valid), 32'h0);

        // Wrap search: pointer sits at 1, only requesters 0 and 3 valid.
        step(4'b1001, 32'h4300_0040, 4'b1001, 1'b1);
        chk("wrap_rdy3", 32'(obs_rdy), 32'h8);
        step(4'b1001, 32'h4300_0040, 4'b1001, 1'b1);
        chk("wrap_rdy0", 32'(obs_rdy), 32'h1);
        chk("wrap_src3", 32'(obs_src), 32'h3);
        step('0, '0, '0, 1'b1);
        chk("wrap_src0", 32'(obs_src), 32'h0);

        // Fairness: all requesters continuously valid, single-beat packets.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) step(4'b1111, 32'h3332_3130, 4'b1111, 1'b1);
            else       step('0, '0, '0, 1'b1);
            if (i > 0) begin
                chk("fair_valid", 32'(obs_valid), 32'h1);
                chk("fair_src",   32'(obs_src),   fair_src[i-1]);
            end
        end

        // Backpressure: output holds 0x22 while downstream is stalled.
        step(4'b0001, 32'h0000_0022, 4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 32'h0000_5500, 4'b0010, 1'b0);
            chk("bp_rdy",   32'(obs_rdy),   32'h0);
            chk("bp_valid", 32'(obs_valid), 32'h1);
            chk("bp_data",  32'(obs_data),  32'h22);
        end
        step(4'b0010, 32'h0000_5500, 4'b0010, 1'b1);
        chk("bp_go_rdy",  32'(obs_rdy),  32'h2);
        chk("bp_go_data", 32'(obs_data), 32'h22);
        step('0, '0, '0, 1'b1);
        chk("bp_next_valid", 32'(obs_valid), 32'h1);
        chk("bp_next_data",  32'(obs_data),  32'h55);
        chk("bp_next_src",   32'(obs_src),   32'h1);

        // Packet lock: requester 1 sends A1..A3, requester 2 waits with B0.
        do_reset();
        a_idx  = 0;
        b_done = 1'b0;
        got_q.delete();
        for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
            tv = '0;
            td = '0;
            tl = '0;
            if (a_idx < 3) begin
                tv[1]     = 1'b1;
                td[W +: W] = 8'(32'hA1 + a_idx);
                tl[1]     = (a_idx == 2);
            end
            if (!b_done) begin
                tv[2]        = 1'b1;
                td[2*W +: W] = 8'hB0;
                tl[2]        = 1'b1;
            end
            step(tv, td, tl, 1'b1);
            if (obs_valid) got_q.push_back(obs_data);
            if (obs_rdy[1]) a_idx++;
            if (obs_rdy[2]) b_done = 1'b1;
        end
        chk("lock_count", got_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            chk("lock_order", 32'(got_q[i]), 32'(exp_lock[i]));
        end

        // Reset asserted mid-packet on requester 2.
        step(4'b0100, 32'h00C0_0000, 4'b0000, 1'b1);
        @(negedge aclk);
        s_valid = '0;
        m_ready = 1'b0;
        #1;
        chk("mid_pre_valid", 32'(m_valid), 32'h1);
        aresetn = 1'b0;
        #1;
        chk("mid_async_valid", 32'(m_valid), 32'h0);
        chk("mid_async_rdy",   32'(s_ready), 32'h0);
        mdl_reset();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        step(4'b1111, 32'h6362_6160, 4'b1111, 1'b1);
        chk("mid_first_rdy", 32'(obs_rdy), 32'h1);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            tv = N'($urandom);
            td = (N*W)'($urandom);
            tl = N'($urandom) & N'($urandom);
            step(tv, td, tl, ($urandom_range(3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
